// File: rtl/cp0_regs.sv
// MIPS coprocessor-0 register file: Status, Cause, EPC, BadVAddr and the Count/Compare timer.
// Exception commits and hardware interrupt sampling share the register state with MFC0/MTC0.
module cp0_regs #(
  parameter bit COUNT_HALF_RATE = 1'b1,
  parameter int TIMER_IP        = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_wdata,
  output logic [31:0] mfc0_rdata,
  input  logic        exc_we,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        clear_exl,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr_in,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_out,
  output logic        allow_int,
  output logic [7:0]  interrupt_flag,
  output logic        timer_int
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic        count_phase;
  logic [31:0] compare;
  logic        compare_armed;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  cause_ip_hw;
  logic [4:0]  cause_exc_code;
  logic [31:0] epc;

  logic        wr_badvaddr;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        count_tick;
  logic [7:0]  cause_ip;

  assign wr_badvaddr = mtc0_we && (cp0_addr == ADDR_BADVADDR);
  assign wr_count    = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign wr_compare  = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign wr_status   = mtc0_we && (cp0_addr == ADDR_STATUS);
  assign wr_cause    = mtc0_we && (cp0_addr == ADDR_CAUSE);
  assign wr_epc      = mtc0_we && (cp0_addr == ADDR_EPC);

  assign count_tick = COUNT_HALF_RATE ? count_phase : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      count_phase <= 1'b0;
    end else if (wr_count) begin
      count       <= mtc0_wdata;
      count_phase <= 1'b0;
    end else begin
      count_phase <= ~count_phase;
      if (count_tick) count <= count + 32'd1;
    end
  end

  // Timer match only counts once Compare has been programmed, so the 0 == 0 reset state never fires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare       <= '0;
      compare_armed <= 1'b0;
      cause_ti      <= 1'b0;
    end else begin
      if (wr_compare) begin
        compare       <= mtc0_wdata;
        compare_armed <= 1'b1;
        cause_ti      <= 1'b0;
      end else if (compare_armed && (count == compare)) begin
        cause_ti      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im <= mtc0_wdata[15:8];
        status_ie <= mtc0_wdata[0];
      end
      if (exc_we)         status_exl <= 1'b1;
      else if (clear_exl) status_exl <= 1'b0;
      else if (wr_status) status_exl <= mtc0_wdata[1];
    end
  end

  // Nested exceptions (EXL already set) keep the original EPC and BD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc            <= '0;
      cause_bd       <= 1'b0;
      cause_exc_code <= '0;
    end else if (exc_we) begin
      cause_exc_code <= exc_code;
      if (!status_exl) begin
        epc      <= exc_bd ? (exc_epc - 32'd4) : exc_epc;
        cause_bd <= exc_bd;
      end
    end else if (wr_epc) begin
      epc <= mtc0_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_ip_sw <= '0;
      cause_ip_hw <= '0;
      badvaddr    <= '0;
    end else begin
      cause_ip_hw <= hw_int;
      if (wr_cause)         cause_ip_sw <= mtc0_wdata[9:8];
      if (badvaddr_we)      badvaddr    <= badvaddr_in;
      else if (wr_badvaddr) badvaddr    <= mtc0_wdata;
    end
  end

  always_comb begin
    cause_ip           = {cause_ip_hw, cause_ip_sw};
    cause_ip[TIMER_IP] = cause_ip[TIMER_IP] | cause_ti;
  end

  always_comb begin
    mfc0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: mfc0_rdata = badvaddr;
      ADDR_COUNT:    mfc0_rdata = count;
      ADDR_COMPARE:  mfc0_rdata = compare;
      ADDR_STATUS:   mfc0_rdata = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
      ADDR_CAUSE:    mfc0_rdata = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc_code, 2'b0};
      ADDR_EPC:      mfc0_rdata = epc;
      default:       mfc0_rdata = '0;
    endcase
  end

  assign epc_out        = epc;
  assign allow_int      = status_ie & ~status_exl;
  assign interrupt_flag = cause_ip & status_im;
  assign timer_int      = cause_ti;

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: a vector table through an expectation queue, then hand-written
// sequences for Count wrap, Compare/TI, hardware interrupts and asynchronous reset.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] mtc0_wdata;
  logic [31:0] mfc0_rdata;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        clear_exl;
  logic        badvaddr_we;
  logic [31:0] badvaddr_in;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic        timer_int;

  cp0_regs dut (
    .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .mtc0_wdata(mtc0_wdata), .mfc0_rdata(mfc0_rdata), .exc_we(exc_we),
    .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd), .clear_exl(clear_exl),
    .badvaddr_we(badvaddr_we), .badvaddr_in(badvaddr_in), .hw_int(hw_int),
    .epc_out(epc_out), .allow_int(allow_int), .interrupt_flag(interrupt_flag),
    .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ew;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        clr;
    logic        bw;
    logic [31:0] bva;
    logic [4:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_allow;
    logic [7:0]  exp_flag;
    logic [31:0] exp_epc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        allow;
    logic [7:0]  flag;
    logic [31:0] epc;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  vec_t vecs[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic mw, logic [4:0] a, logic [31:0] wd,
                              logic ew, logic [4:0] c, logic [31:0] ep, logic bd,
                              logic clr, logic bw, logic [31:0] bv, logic [4:0] ra,
                              logic [31:0] er, logic ea, logic [7:0] ef, logic [31:0] ee);
    vec_t v;
    v.mw = mw; v.addr = a; v.wdata = wd; v.ew = ew; v.code = c; v.epc = ep; v.bd = bd;
    v.clr = clr; v.bw = bw; v.bva = bv; v.rd_addr = ra; v.exp_rd = er;
    v.exp_allow = ea; v.exp_flag = ef; v.exp_epc = ee;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = mfc0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cp0_addr   = a;
    mtc0_wdata = d;
    mtc0_we    = 1'b1;
    @(posedge clk);
    #1;
    mtc0_we = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    exp_t        e;
    bit          found;

    resetn = 1'b0; mtc0_we = 0; cp0_addr = 0; mtc0_wdata = 0; exc_we = 0; exc_code = 0;
    exc_epc = 0; exc_bd = 0; clear_exl = 0; badvaddr_we = 0; badvaddr_in = 0; hw_int = 0;

    //          mw addr wdata         ew code  epc           bd clr bw bva           rd  exp_rd        al flag   exp_epc
    vecs[0]  = mk(1, 12, 32'hFFFF_FFFF, 0, 0,    0,            0, 0,  0, 0,            12, 32'h0040_FF03, 0, 8'h00, 32'h0);
    vecs[1]  = mk(0, 13, 0,             0, 0,    0,            0, 0,  0, 0,            13, 32'h0,         0, 8'h00, 32'h0);
    vecs[2]  = mk(1, 12, 32'h1,         0, 0,    0,            0, 0,  0, 0,            12, 32'h0040_0001, 1, 8'h00, 32'h0);
    vecs[3]  = mk(0, 14, 0,             1, 5'h0C,32'hBFC0_0104,1, 0,  0, 0,            14, 32'hBFC0_0100, 0, 8'h00, 32'hBFC0_0100);
    vecs[4]  = mk(0, 13, 0,             0, 0,    0,            0, 0,  0, 0,            13, 32'h8000_0030, 0, 8'h00, 32'hBFC0_0100);
    vecs[5]  = mk(0, 14, 0,             1, 5'h04,32'h0000_1234,0, 0,  0, 0,            14, 32'hBFC0_0100, 0, 8'h00, 32'hBFC0_0100);
    vecs[6]  = mk(0, 13, 0,             0, 0,    0,            0, 0,  0, 0,            13, 32'h8000_0010, 0, 8'h00, 32'hBFC0_0100);
    vecs[7]  = mk(0, 12, 0,             1, 5'h08,32'h0000_5678,0, 1,  0, 0,            12, 32'h0040_0003, 0, 8'h00, 32'hBFC0_0100);
    vecs[8]  = mk(0, 12, 0,             0, 0,    0,            0, 1,  0, 0,            12, 32'h0040_0001, 1, 8'h00, 32'hBFC0_0100);
    vecs[9]  = mk(1, 14, 32'h8000_0180, 0, 0,    0,            0, 0,  0, 0,            14, 32'h8000_0180, 1, 8'h00, 32'h8000_0180);
    vecs[10] = mk(1, 8,  32'h1111_1111, 0, 0,    0,            0, 0,  1, 32'hDEAD_BEEF,8,  32'hDEAD_BEEF, 1, 8'h00, 32'h8000_0180);
    vecs[11] = mk(1, 14, 32'hAAAA_AAAA, 1, 5'h05,32'h0040_0020,0, 0,  0, 0,            14, 32'h0040_0020, 0, 8'h00, 32'h0040_0020);
    vecs[12] = mk(1, 12, 32'h0000_FF00, 1, 5'h0D,32'h0000_0999,1, 0,  0, 0,            12, 32'h0040_FF02, 0, 8'h00, 32'h0040_0020);
    vecs[13] = mk(1, 5,  32'hFFFF_FFFF, 0, 0,    0,            0, 0,  0, 0,            5,  32'h0,         0, 8'h00, 32'h0040_0020);
    vecs[14] = mk(1, 13, 32'hFFFF_FFFF, 0, 0,    0,            0, 0,  0, 0,            13, 32'h0000_0334, 0, 8'h03, 32'h0040_0020);
    vecs[15] = mk(1, 13, 32'h0,         0, 0,    0,            0, 0,  0, 0,            13, 32'h0000_0034, 0, 8'h00, 32'h0040_0020);
    vecs[16] = mk(0, 12, 0,             0, 0,    0,            0, 1,  0, 0,            12, 32'h0040_FF00, 0, 8'h00, 32'h0040_0020);

    #12;
    rd(12, v); check("reset_status", v, 32'h0040_0000);
    rd(13, v); check("reset_cause", v, 32'h0);
    rd(8, v);  check("reset_badvaddr", v, 32'h0);
    check("reset_epc_out", epc_out, 32'h0);
    check("reset_allow", {31'b0, allow_int}, 32'h0);
    check("reset_flag", {24'b0, interrupt_flag}, 32'h0);
    check("reset_ti", {31'b0, timer_int}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      mtc0_we = vecs[i].mw; cp0_addr = vecs[i].addr; mtc0_wdata = vecs[i].wdata;
      exc_we = vecs[i].ew; exc_code = vecs[i].code; exc_epc = vecs[i].epc; exc_bd = vecs[i].bd;
      clear_exl = vecs[i].clr; badvaddr_we = vecs[i].bw; badvaddr_in = vecs[i].bva;
      sbq.push_back('{i, vecs[i].exp_rd, vecs[i].exp_allow, vecs[i].exp_flag, vecs[i].exp_epc});
      @(posedge clk);
      #1;
      mtc0_we = 0; exc_we = 0; clear_exl = 0; badvaddr_we = 0;
      cp0_addr = vecs[i].rd_addr;
      #1;
      if (sbq.size() == 0) begin
        check($sformatf("vec%0d_queue", i), 32'h0, 32'h1);
      end else begin
        e = sbq.pop_front();
        check($sformatf("vec%0d_rdata", e.idx), mfc0_rdata, e.rd);
        check($sformatf("vec%0d_allow", e.idx), {31'b0, allow_int}, {31'b0, e.allow});
        check($sformatf("vec%0d_flag", e.idx), {24'b0, interrupt_flag}, {24'b0, e.flag});
        check($sformatf("vec%0d_epc_out", e.idx), epc_out, e.epc);
      end
    end

    // Count wrap at half rate
    mtc0(9, 32'hFFFF_FFFE);
    rd(9, v); check("count_load", v, 32'hFFFF_FFFE);
    tick; rd(9, v); check("count_1", v, 32'hFFFF_FFFE);
    tick; rd(9, v); check("count_2", v, 32'hFFFF_FFFF);
    tick; rd(9, v); check("count_3", v, 32'hFFFF_FFFF);
    tick; rd(9, v); check("count_wrap", v, 32'h0);

    // Compare/TI (IM is 0xFF here)
    mtc0(11, 32'd10);
    rd(11, v); check("compare_rd", v, 32'd10);
    mtc0(9, 32'd0);
    found = 0;
    for (int n = 0; n < 60; n++) begin
      rd(9, v);
      if (v == 32'd10) begin
        found = 1;
        break;
      end
      tick;
    end
    check("count_reach_10", {31'b0, found}, 32'h1);
    check("ti_before", {31'b0, timer_int}, 32'h0);
    tick;
    check("ti_set", {31'b0, timer_int}, 32'h1);
    check("ti_flag", {24'b0, interrupt_flag}, 32'h80);
    rd(13, v); check("ti_cause", v, 32'h4000_8034);
    tick;
    check("ti_sticky", {31'b0, timer_int}, 32'h1);
    mtc0(11, 32'd100);
    check("ti_cleared", {31'b0, timer_int}, 32'h0);
    check("ti_flag_cleared", {24'b0, interrupt_flag}, 32'h0);

    // Hardware interrupt sampling
    mtc0(12, 32'h0000_0401);
    @(negedge clk);
    hw_int = 6'b000001;
    #1;
    check("hw_latency", {24'b0, interrupt_flag}, 32'h0);
    tick;
    check("hw_flag", {24'b0, interrupt_flag}, 32'h04);
    mtc0(13, 32'h0000_0200);
    check("sw_ip1_masked", {24'b0, interrupt_flag}, 32'h04);
    rd(13, v); check("cause_ip", v, 32'h0000_0634);
    mtc0(12, 32'h0000_0601);
    check("sw_ip1_enabled", {24'b0, interrupt_flag}, 32'h06);
    check("allow_ie", {31'b0, allow_int}, 32'h1);
    @(negedge clk);
    hw_int = 6'b0;
    tick;
    check("hw_drop", {24'b0, interrupt_flag}, 32'h02);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_epc_out", epc_out, 32'h0);
    check("arst_allow", {31'b0, allow_int}, 32'h0);
    check("arst_flag", {24'b0, interrupt_flag}, 32'h0);
    rd(12, v); check("arst_status", v, 32'h0040_0000);
    rd(13, v); check("arst_cause", v, 32'h0);
    rd(11, v); check("arst_compare", v, 32'h0);
    rd(8, v);  check("arst_badvaddr", v, 32'h0);
    @(negedge clk);
    rd(9, v);  check("arst_count", v, 32'h0);
    resetn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
